mem_fill_responder: RTL and testbench

- Memory-side responder for the mining write/read sequencing controller.
- Owns a DEPTH-word buffer RAM and accepts a word stream while the controller holds we=1.
- Reports end-of-fill on fine_scrittura, then serves words at the controller-driven indirizzo_read.
- Pulses fine_scrittura as the per-word advance strobe during readout, and fine_lettura after the last word is delivered.

---
 rtl/mem_fill_responder.sv | 151 +++++++++++++++
 tb/tb_mem_fill_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_responder.sv
// Buffer-side responder for the mining write/read controller: fills a DEPTH-word RAM
// from a valid/ready stream, then serves one word per controller-supplied address.
module mem_fill_responder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] indirizzo_read,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              fine_scrittura,
  output logic              fine_lettura,
  output logic              busy
);

  localparam int PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAIT_CYCLES = 1;

  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]        WAIT_LAST = 2'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, FULL, RD_ISSUE, RD_VALID, RD_WAIT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              fs_q, fs_d;
  logic              fl_q, fl_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;

  // Addresses past the buffer read back as zero rather than aliasing into it.
  assign in_range = {1'b0, indirizzo_read} < DEPTH_EXT;
  assign rd_word  = in_range ? mem[indirizzo_read[PTR_W-1:0]] : '0;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wait_cnt_d  = wait_cnt_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    fs_d        = 1'b0;
    fl_d        = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (we) begin
          state_d  = FILL;
          wr_ptr_d = '0;
        end
      end
      FILL: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            state_d  = FULL;
            fs_d     = 1'b1;
          end
        end
      end
      FULL: begin
        if (!we) state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        rd_addr_d   = indirizzo_read;
        out_data_d  = rd_word;
        out_valid_d = 1'b1;
        state_d     = RD_VALID;
      end
      RD_VALID: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (rd_addr_q == LAST_ADDR) begin
            fl_d    = 1'b1;
            state_d = DONE;
          end else begin
            fs_d       = 1'b1;
            wait_cnt_d = '0;
            state_d    = RD_WAIT;
          end
        end
      end
      // Gives the controller one cycle to advance indirizzo_read after the strobe.
      RD_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = RD_ISSUE;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      fs_q        <= 1'b0;
      fl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      fs_q        <= fs_d;
      fl_q        <= fl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_data;
  end

  assign in_ready  = (state_q == FILL);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  // A pulse already in flight is masked the moment reset is raised.
  assign fine_scrittura = fs_q & ~reset;
  assign fine_lettura   = fl_q & ~reset;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench for mem_fill_responder: randomized fills and handshakes
// compared against an array model of the buffer and the readout timing rules.
module tb_mem_fill_responder;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              we;
  logic [ADDR_W-1:0] indirizzo_read;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              fine_scrittura;
  logic              fine_lettura;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  int                addr_list [$];

  mem_fill_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .we            (we),
    .indirizzo_read(indirizzo_read),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .fine_scrittura(fine_scrittura),
    .fine_lettura  (fine_lettura),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic w, input logic iv, input logic [DATA_W-1:0] d,
                               input logic ordy);
    we        = w;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed,
             expected, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_word(input int a);
    return (a >= 0 && a < DEPTH) ? model_mem[a] : '0;
  endfunction

  // Starts from IDLE/DONE, streams DEPTH words, then offers one extra word in FULL.
  task automatic fill_job(input bit rand_data, input bit gaps);
    logic [DATA_W-1:0] d;
    int                ng;
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    tick();
    checkOutput("fill_start_ready", 32'(in_ready), 1);
    checkOutput("fill_start_busy", 32'(busy), 1);
    for (int i = 0; i < DEPTH; i++) begin
      ng = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < ng; g++) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'b0);
        tick();
        checkOutput("fill_gap_ready", 32'(in_ready), 1);
        checkOutput("fill_gap_pulse", 32'(fine_scrittura), 0);
      end
      d = rand_data ? $urandom : DATA_W'(i);
      applyStimulus((gaps && i != DEPTH - 1) ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1, d, 1'b0);
      model_mem[i] = d;
      tick();
      if (i < DEPTH - 1) begin
        checkOutput("fill_ready", 32'(in_ready), 1);
        checkOutput("fill_early_pulse", 32'(fine_scrittura), 0);
      end
    end
    checkOutput("fill_done_pulse", 32'(fine_scrittura), 1);
    checkOutput("fill_done_ready", 32'(in_ready), 0);
    checkOutput("fill_done_lettura", 32'(fine_lettura), 0);
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();
    checkOutput("overflow_pulse_cleared", 32'(fine_scrittura), 0);
    checkOutput("overflow_ready", 32'(in_ready), 0);
    checkOutput("full_busy", 32'(busy), 1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
  endtask

  // Drops we and acts as the controller, walking addr_list one strobe at a time.
  task automatic read_job(input int abort_idx, input int stall_idx, input int stall_len,
                          input bit rand_ready);
    int   k = 0, hs = -100, nv, guard = 0, strobes = 0, stall_left;
    bit   exp_valid = 1'b0, pend = 1'b0, fin = 1'b0, last_done;
    logic exp_fs, exp_fl;
    stall_left     = stall_len;
    indirizzo_read = ADDR_W'(addr_list[0]);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    nv = cyc + 2;
    while (!fin && guard < 500) begin
      tick();
      guard++;
      if (pend) begin
        indirizzo_read = ADDR_W'(addr_list[k]);
        pend = 1'b0;
      end
      if (cyc == nv) exp_valid = 1'b1;
      last_done = (k > 0) && (addr_list[k-1] == DEPTH - 1);
      exp_fs    = (cyc == hs + 1) && !last_done;
      exp_fl    = (cyc == hs + 1) && last_done;
      if (abort_idx >= 0 && exp_fs && (k - 1) == abort_idx) begin
        reset = 1'b1;
        #1;
        checkOutput("abort_no_strobe", 32'(fine_scrittura), 0);
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_out_valid", 32'(out_valid), 0);
        checkOutput("abort_in_ready", 32'(in_ready), 0);
        checkOutput("abort_pulse", 32'(fine_scrittura), 0);
        return;
      end
      checkOutput("fine_scrittura", 32'(fine_scrittura), 32'(exp_fs));
      checkOutput("fine_lettura", 32'(fine_lettura), 32'(exp_fl));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) checkOutput("out_data", out_data, ref_word(addr_list[k]));
      if (fine_scrittura) begin
        strobes++;
        pend = 1'b1;
      end
      if (exp_fl) begin
        tick();
        checkOutput("done_busy", 32'(busy), 0);
        checkOutput("done_lettura_cleared", 32'(fine_lettura), 0);
        checkOutput("done_out_valid", 32'(out_valid), 0);
        checkOutput("strobe_count", strobes, addr_list.size() - 1);
        fin = 1'b1;
      end else if (exp_valid) begin
        if (k == stall_idx && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          hs        = cyc;
          exp_valid = 1'b0;
          k++;
          nv        = cyc + 3;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    checkOutput("read_finished", 32'(fin), 1);
  endtask

  initial begin
    reset          = 1'b1;
    indirizzo_read = '0;
    applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1);
    tick();
    tick();
    checkOutput("reset_in_ready", 32'(in_ready), 0);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_fine_scrittura", 32'(fine_scrittura), 0);
    checkOutput("reset_fine_lettura", 32'(fine_lettura), 0);
    checkOutput("reset_busy", 32'(busy), 0);

    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_in_ready", 32'(in_ready), 0);

    $display("[TB] counting fill and full readout with stall on word 3");
    fill_job(1'b0, 1'b0);
    addr_list.delete();
    for (int i = 0; i < DEPTH; i++) addr_list.push_back(i);
    read_job(-1, 3, 5, 1'b0);

    $display("[TB] random fill, reset during RD_WAIT after word 7");
    fill_job(1'b1, 1'b1);
    read_job(7, -1, 0, 1'b1);

    $display("[TB] fresh random fill and full readout after reset");
    fill_job(1'b1, 1'b1);
    read_job(-1, -1, 0, 1'b1);

    $display("[TB] refill from DONE, out-of-range address first");
    fill_job(1'b1, 1'b0);
    addr_list.delete();
    addr_list.push_back(20);
    addr_list.push_back(0);
    addr_list.push_back(9);
    addr_list.push_back(DEPTH - 1);
    read_job(-1, -1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
